trail_painter: RTL and testbench

Trail-RAM write/collision engine for the light-cycle game, sitting between the player FSM and the frame trail RAM. On each player step it receives the new 8x8 head cell, reads every pixel of that cell from the trail RAM to detect a collision, and writes the player's ID into all 64 pixels. It also performs a full-RAM clear on restart. The VGA scanout keeps its own RAM read port; this block owns the RAM write port and a second read port.

---
 rtl/trail_painter.sv | 175 +++++++++++++++++
 tb/tb_trail_painter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trail_painter.sv
// Trail-RAM collision/paint engine: reads each pixel of an 8x8 head cell, flags hits, paints player_id.
// Latency: step = 67 cycles start->done (2 for out-of-bounds cell); full clear = H_RES*V_RES+1 cycles.
// Backpressure: none; start is ignored while busy, clear aborts a step and restarts as a full RAM clear.
module trail_painter #(
  parameter int CELL        = 8,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int ARENA_MIN_X = 16,
  parameter int ARENA_MAX_X = 623,
  parameter int ARENA_MIN_Y = 16,
  parameter int ARENA_MAX_Y = 463
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic [9:0]  cell_x,
  input  logic [9:0]  cell_y,
  input  logic [7:0]  player_id,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic [18:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wren
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SCAN  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [18:0] STRIDE    = 19'(H_RES);
  localparam logic [18:0] LAST_ADDR = 19'(H_RES * V_RES - 1);
  localparam logic [10:0] SPAN      = 11'(CELL - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [7:0]  r_id;
  // Scan index: 0..63 issue reads, 64 is the final write-only cycle.
  logic [6:0]  r_k;
  logic        r_collision;
  logic [18:0] r_rd_addr;
  logic [18:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_wren;

  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic        w_oob;
  logic [5:0]  w_pix;
  logic [18:0] w_row;
  logic [18:0] w_pix_addr;

  // Bounds test on the latched cell, 11 bits wide so x+7 / y+7 cannot wrap.
  assign w_x11 = {1'b0, r_x};
  assign w_y11 = {1'b0, r_y};
  assign w_oob = (w_x11 < 11'(ARENA_MIN_X)) || ((w_x11 + SPAN) > 11'(ARENA_MAX_X)) ||
                 (w_y11 < 11'(ARENA_MIN_Y)) || ((w_y11 + SPAN) > 11'(ARENA_MAX_Y));

  // Address of the next pixel to read: pixel 0 from CHECK, pixel k+1 while scanning.
  assign w_pix      = (r_state == SCAN) ? (r_k[5:0] + 6'd1) : 6'd0;
  assign w_row      = {9'd0, r_y} + {16'd0, w_pix[5:3]};
  assign w_pix_addr = (w_row * STRIDE) + {9'd0, r_x} + {16'd0, w_pix[2:0]};

  // State register.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; clear wins over start and aborts CHECK/SCAN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (clear)      w_state_nxt = CLEAR;
        else if (start) w_state_nxt = CHECK;
        else            w_state_nxt = IDLE;
      end
      CHECK: begin
        if (clear)      w_state_nxt = CLEAR;
        else if (w_oob) w_state_nxt = DONE;
        else            w_state_nxt = SCAN;
      end
      SCAN: begin
        if (clear)        w_state_nxt = CLEAR;
        else if (r_k[6])  w_state_nxt = DONE;
      end
      CLEAR: begin
        if (r_wr_addr == LAST_ADDR) w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the cell, pipeline read->write by one cycle, run the clear counter.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_id        <= '0;
      r_k         <= '0;
      r_collision <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wren      <= 1'b0;
    end else if ((w_state_nxt == CLEAR) && (r_state != CLEAR)) begin
      // Entering CLEAR: any pending paint write is replaced by the first zero write.
      r_wren      <= 1'b1;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_collision <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          r_wren <= 1'b0;
          if (w_state_nxt == CHECK) begin
            r_x  <= cell_x;
            r_y  <= cell_y;
            r_id <= player_id;
          end
        end
        CHECK: begin
          r_k <= '0;
          if (w_oob) begin
            r_collision <= 1'b1;
          end else begin
            r_collision <= 1'b0;
            r_rd_addr   <= w_pix_addr;
          end
        end
        SCAN: begin
          // rd_data belongs to the address now being written.
          if (r_wren && (rd_data != 8'h00)) r_collision <= 1'b1;
          if (!r_k[6]) begin
            r_wren    <= 1'b1;
            r_wr_addr <= r_rd_addr;
            r_wr_data <= r_id;
            if (r_k != 7'd63) r_rd_addr <= w_pix_addr;
          end else begin
            r_wren <= 1'b0;
          end
          r_k <= r_k + 7'd1;
        end
        CLEAR: begin
          if (r_wr_addr == LAST_ADDR) r_wren <= 1'b0;
          else                        r_wr_addr <= r_wr_addr + 19'd1;
        end
        default: r_wren <= 1'b0;
      endcase
    end
  end

  assign busy      = (r_state == CHECK) || (r_state == SCAN) || (r_state == CLEAR);
  assign done      = (r_state == DONE);
  assign collision = r_collision;
  assign rd_addr   = r_rd_addr;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wren      = r_wren;

endmodule

// File: tb/tb_trail_painter.sv
// Directed bench for trail_painter with a sparse trail-RAM model.
// Frame height is reduced so a full clear stays short; cell addresses use the real 640 stride.
module tb_trail_painter;

  localparam int VRES_TB = 24;
  localparam int NCLR    = 640 * VRES_TB;

  logic        VGA_CLK = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        clear   = 1'b0;
  logic [9:0]  cell_x  = '0;
  logic [9:0]  cell_y  = '0;
  logic [7:0]  player_id = '0;
  logic        busy, done, collision, wren;
  logic [18:0] rd_addr, wr_addr;
  logic [7:0]  rd_data = '0;
  logic [7:0]  wr_data;

  logic [7:0]  mem [int];

  int n_chk = 0;
  int n_bad = 0;

  int s_done_cyc, s_nwr, s_bad_wr, s_bad_rd, s_busy_bad, s_coll, s_extra;

  trail_painter #(.V_RES(VRES_TB)) dut (
    .VGA_CLK  (VGA_CLK),
    .reset    (reset),
    .start    (start),
    .clear    (clear),
    .cell_x   (cell_x),
    .cell_y   (cell_y),
    .player_id(player_id),
    .busy     (busy),
    .done     (done),
    .collision(collision),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wren     (wren)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Trail RAM: registered read (1-cycle latency), synchronous write.
  always @(posedge VGA_CLK) begin
    rd_data <= mem.exists(int'(rd_addr)) ? mem[int'(rd_addr)] : 8'h00;
    if (wren) mem[int'(wr_addr)] = wr_data;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pa(input int x, input int y, input int k);
    return (y + k / 8) * 640 + x + k % 8;
  endfunction

  function automatic int rd_mem(input int a);
    return mem.exists(a) ? int'(mem[a]) : 0;
  endfunction

  // Call right after start was raised at a negedge; cycle c is sampled at the c-th following negedge.
  task automatic scan_watch(input int x, input int y, input logic [7:0] id,
                            input int exp_done, input int clr_at, input int start_at);
    int k;
    s_done_cyc = -1; s_nwr = 0; s_bad_wr = 0; s_bad_rd = 0;
    s_busy_bad = 0; s_coll = -1; s_extra = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge VGA_CLK);
      start = 1'b0;
      if (wren) begin
        k = c - 3;
        s_nwr++;
        if (k < 0 || k > 63) s_bad_wr++;
        else if (int'(wr_addr) != pa(x, y, k) || wr_data != id) s_bad_wr++;
      end
      if (exp_done == 67 && c >= 2 && c <= 65 && int'(rd_addr) != pa(x, y, c - 2)) s_bad_rd++;
      if (busy != (c < exp_done)) s_busy_bad++;
      if (done) begin
        s_done_cyc = c;
        s_coll = int'(collision);
        break;
      end
      if (c == clr_at) begin
        clear = 1'b1;
        return;
      end
      if (c == start_at) begin
        cell_x = 10'd100; cell_y = 10'd100; player_id = 8'h80; start = 1'b1;
      end
    end
    if (s_done_cyc > 0) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge VGA_CLK);
        if (done || wren) s_extra++;
      end
    end
  endtask

  task automatic do_step(input int x, input int y, input logic [7:0] id,
                         input int exp_done, input int clr_at, input int start_at);
    @(negedge VGA_CLK);
    cell_x = 10'(x); cell_y = 10'(y); player_id = id; start = 1'b1;
    scan_watch(x, y, id, exp_done, clr_at, start_at);
  endtask

  // Call right after clear was raised at a negedge.
  task automatic clear_watch;
    s_done_cyc = -1; s_nwr = 0; s_bad_wr = 0; s_busy_bad = 0; s_coll = -1;
    for (int c = 1; c <= NCLR + 8; c++) begin
      @(negedge VGA_CLK);
      clear = 1'b0;
      if (wren) begin
        s_nwr++;
        if (int'(wr_addr) != c - 1 || wr_data != 8'h00) s_bad_wr++;
      end
      if (busy != (c <= NCLR)) s_busy_bad++;
      if (done) begin
        s_done_cyc = c;
        s_coll = int'(collision);
        break;
      end
    end
  endtask

  initial begin
    int ev;
    repeat (3) @(negedge VGA_CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_coll", collision, 0);
    chk("rst_wren", wren, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b0;

    // Clean step on zeroed RAM.
    do_step(216, 240, 8'h01, 67, 0, 0);
    chk("t1_done_cyc", s_done_cyc, 67);
    chk("t1_nwr", s_nwr, 64);
    chk("t1_bad_wr", s_bad_wr, 0);
    chk("t1_bad_rd", s_bad_rd, 0);
    chk("t1_busy", s_busy_bad, 0);
    chk("t1_coll", s_coll, 0);
    chk("t1_extra", s_extra, 0);
    chk("t1_first", rd_mem(153816), 1);
    chk("t1_last", rd_mem(158303), 1);

    // Out of bounds on the right edge.
    do_step(620, 100, 8'h01, 2, 0, 0);
    chk("oobx_done_cyc", s_done_cyc, 2);
    chk("oobx_nwr", s_nwr, 0);
    chk("oobx_busy", s_busy_bad, 0);
    chk("oobx_coll", s_coll, 1);

    // Full clear from IDLE clears the sticky collision.
    @(negedge VGA_CLK);
    clear = 1'b1;
    clear_watch();
    chk("clr_done_cyc", s_done_cyc, NCLR + 1);
    chk("clr_nwr", s_nwr, NCLR);
    chk("clr_bad_wr", s_bad_wr, 0);
    chk("clr_busy", s_busy_bad, 0);
    chk("clr_coll", s_coll, 0);

    // Other out-of-bounds edges.
    do_step(8, 100, 8'h01, 2, 0, 0);
    chk("oobxl_done_cyc", s_done_cyc, 2);
    chk("oobxl_coll", s_coll, 1);
    do_step(300, 460, 8'h01, 2, 0, 0);
    chk("ooby_done_cyc", s_done_cyc, 2);
    chk("ooby_nwr", s_nwr, 0);
    chk("ooby_coll", s_coll, 1);

    // Collision against the other player's trail; the whole head still gets painted.
    mem.delete();
    mem[243 * 640 + 220] = 8'h80;
    do_step(216, 240, 8'h01, 67, 0, 0);
    chk("hit_done_cyc", s_done_cyc, 67);
    chk("hit_nwr", s_nwr, 64);
    chk("hit_bad_wr", s_bad_wr, 0);
    chk("hit_coll", s_coll, 1);
    chk("hit_painted", rd_mem(243 * 640 + 220), 1);

    // Reset mid-step forces outputs to reset values and cancels the step.
    @(negedge VGA_CLK);
    cell_x = 10'd200; cell_y = 10'd50; player_id = 8'h01; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge VGA_CLK);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge VGA_CLK);
    chk("rmid_ctrl", {busy, done, collision, wren}, 0);
    chk("rmid_rd_addr", rd_addr, 0);
    chk("rmid_wr_addr", wr_addr, 0);
    chk("rmid_wr_data", wr_data, 0);
    reset = 1'b0;
    ev = 0;
    repeat (70) begin
      @(negedge VGA_CLK);
      if (done || wren || busy) ev++;
    end
    chk("rmid_quiet", ev, 0);

    // Right-most legal cell.
    do_step(616, 100, 8'h01, 67, 0, 0);
    chk("edge_done_cyc", s_done_cyc, 67);
    chk("edge_nwr", s_nwr, 64);
    chk("edge_bad_wr", s_bad_wr, 0);
    chk("edge_bad_rd", s_bad_rd, 0);
    chk("edge_coll", s_coll, 0);

    // start while busy is ignored.
    do_step(400, 300, 8'h80, 67, 0, 20);
    chk("ign_done_cyc", s_done_cyc, 67);
    chk("ign_nwr", s_nwr, 64);
    chk("ign_bad_wr", s_bad_wr, 0);
    chk("ign_extra", s_extra, 0);

    // clear at cycle 30 of a scan aborts it and restarts as a clear from address 0.
    do_step(300, 200, 8'h01, 67, 30, 0);
    chk("abt_no_done", s_done_cyc, -1);
    chk("abt_nwr", s_nwr, 28);
    clear_watch();
    chk("abt_clr_done_cyc", s_done_cyc, NCLR + 1);
    chk("abt_clr_nwr", s_nwr, NCLR);
    chk("abt_clr_bad_wr", s_bad_wr, 0);
    chk("abt_clr_coll", s_coll, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
